// File: rtl/qn17_pkg.sv
// ---------------------------------------------------------------------------
// qn17_pkg -- shared definitions for the event UART transmitter.
//
// Contents:
//   state_t     : sequencer FSM states (IDLE, REQ, WAIT_VALID, SEND, GAP)
//   SYNC_BYTE   : first byte of every frame (0xA5)
//   FRAME_BYTES : bytes per frame; 3 by default, 4 when EVT_CHECKSUM_EN is
//                 defined (the 4th byte is the XOR of the first three)
//
// Build macro: EVT_CHECKSUM_EN
// ---------------------------------------------------------------------------
package qn17_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REQ        = 3'd1,
        WAIT_VALID = 3'd2,
        SEND       = 3'd3,
        GAP        = 3'd4
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef EVT_CHECKSUM_EN
    localparam int FRAME_BYTES = 4;
`else
    localparam int FRAME_BYTES = 3;
`endif

endpackage

// File: rtl/uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte -- 8N1 serialiser for a single byte.
//
// Parameters:
//   BAUD_DIV : clock cycles per bit (4..65535)
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   start  in   load data and begin a start bit on the next edge; accepted
//               when idle or in the last cycle of a stop bit (done=1), so
//               consecutive bytes can follow each other without idle bits
//   data   in   [7:0] byte to send, sampled together with start
//   tx     out  registered serial line, idle high
//   done   out  high during the final cycle of the stop bit
// ---------------------------------------------------------------------------
module uart_tx_byte #(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    logic        active;
    logic [15:0] baud_cnt;
    logic [3:0]  bit_idx;   // 0 = start bit, 1..8 = data bits, 9 = stop bit
    logic [7:0]  shreg;
    logic        tx_q;
    logic        bit_end;

    assign bit_end = active && (baud_cnt == BAUD_LAST);
    assign done    = bit_end && (bit_idx == 4'd9);
    assign tx      = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else if (start && (!active || done)) begin
            active   <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= data;
            tx_q     <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                    tx_q   <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    // Leaving data bit 8 (MSB) means the stop bit comes next.
                    tx_q    <= (bit_idx == 4'd8) ? 1'b1 : shreg[0];
                    shreg   <= {1'b0, shreg[7:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/event_uart_tx.sv
// ---------------------------------------------------------------------------
// event_uart_tx -- reads 16-bit event words from a FIFO and sends each one
// as a UART frame: 0xA5, OTUBE[15:8], OTUBE[7:0] (plus an XOR checksum byte
// when EVT_CHECKSUM_EN is defined), followed by one idle bit period.
//
// Parameters:
//   BAUD_DIV      : clk100 cycles per UART bit (4..65535)
//   VALID_TIMEOUT : cycles to wait for RD_VALID after RD_EN
// Ports:
//   clk100       in   system clock, also clocks the FIFO read port
//   rst_n        in   asynchronous active-low reset
//   RD_EMPTY     in   FIFO empty flag
//   RD_VALID     in   FIFO read data valid
//   OTUBE        in   [15:0] FIFO read data
//   RD_EN        out  one-cycle read request per word
//   UART_TX      out  serial line, 8N1, idle high
//   TX_BUSY      out  high from the RD_EN pulse to the end of the last stop bit
//   FRAME_COUNT  out  [15:0] frames completed since reset (wraps)
//   RD_ERR       out  sticky: a read timed out
//   dbg_state    out  current sequencer state
//
// Build macro: EVT_CHECKSUM_EN
//
// FIFO handshake: RD_EN is a single-cycle request issued only while
// RD_EMPTY=0. The word is taken on the first cycle in WAIT_VALID with
// RD_VALID=1; RD_VALID/OTUBE are ignored in every other state. If no
// RD_VALID arrives within VALID_TIMEOUT cycles the request is abandoned and
// RD_ERR is set.
// ---------------------------------------------------------------------------
module event_uart_tx
    import qn17_pkg::*;
#(
    parameter int BAUD_DIV      = 868,
    parameter int VALID_TIMEOUT = 15
) (
    input  logic        clk100,
    input  logic        rst_n,
    input  logic        RD_EMPTY,
    input  logic        RD_VALID,
    input  logic [15:0] OTUBE,
    output logic        RD_EN,
    output logic        UART_TX,
    output logic        TX_BUSY,
    output logic [15:0] FRAME_COUNT,
    output logic        RD_ERR,
    output state_t      dbg_state
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] WAIT_LAST = 16'(VALID_TIMEOUT - 1);
    localparam logic [1:0]  BYTE_LAST = 2'(FRAME_BYTES - 1);

    logic [1:0]  rst_sync;
    logic        run;
    state_t      state_q;
    logic        rd_en_q;
    logic        busy_q;
    logic [15:0] frame_count_q;
    logic        rd_err_q;
    logic [15:0] word_q;
    logic [1:0]  byte_idx;
    logic [15:0] wait_cnt;
    logic [15:0] gap_cnt;

    logic        byte_start;
    logic [7:0]  byte_data;
    logic        byte_done;
    logic        last_byte;

    // Reset asserts asynchronously everywhere; release only lets the FSM
    // leave IDLE after two clean edges.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign run = rst_sync[1];

`ifdef EVT_CHECKSUM_EN
    logic [7:0] checksum;
    assign checksum = SYNC_BYTE ^ word_q[15:8] ^ word_q[7:0];
`endif

    assign last_byte = (byte_idx == BYTE_LAST);

    // The sync byte starts in the same cycle RD_VALID is seen, so its start
    // bit appears right after that edge. Later bytes are chained on done.
    always_comb begin
        byte_start = 1'b0;
        byte_data  = SYNC_BYTE;
        if (state_q == WAIT_VALID && RD_VALID) begin
            byte_start = 1'b1;
        end else if (state_q == SEND && byte_done && !last_byte) begin
            byte_start = 1'b1;
            case (byte_idx)
                2'd0:    byte_data = word_q[15:8];
                2'd1:    byte_data = word_q[7:0];
`ifdef EVT_CHECKSUM_EN
                2'd2:    byte_data = checksum;
`endif
                default: byte_data = SYNC_BYTE;
            endcase
        end
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rd_en_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
            rd_err_q      <= 1'b0;
            word_q        <= '0;
            byte_idx      <= '0;
            wait_cnt      <= '0;
            gap_cnt       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run && !RD_EMPTY) begin
                        state_q <= REQ;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                REQ: begin
                    rd_en_q  <= 1'b0;
                    wait_cnt <= '0;
                    state_q  <= WAIT_VALID;
                end
                WAIT_VALID: begin
                    if (RD_VALID) begin
                        word_q   <= OTUBE;
                        byte_idx <= '0;
                        state_q  <= SEND;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rd_err_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                SEND: begin
                    if (byte_done) begin
                        if (last_byte) begin
                            busy_q        <= 1'b0;
                            frame_count_q <= frame_count_q + 16'd1;
                            gap_cnt       <= '0;
                            state_q       <= GAP;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == BAUD_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rd_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_byte (
        .clk   (clk100),
        .rst_n (rst_n),
        .start (byte_start),
        .data  (byte_data),
        .tx    (UART_TX),
        .done  (byte_done)
    );

    // Masking with RD_EMPTY guarantees no read request ever reaches an
    // empty FIFO, even if the flag changes under a pending request.
    assign RD_EN       = rd_en_q & ~RD_EMPTY;
    assign TX_BUSY     = busy_q;
    assign FRAME_COUNT = frame_count_q;
    assign RD_ERR      = rd_err_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/event_uart_tx.md
EVENT_UART_TX -- requirements
Module: event_uart_tx

Interface
REQ-001 Parameter BAUD_DIV, default 868: clk100 cycles per UART bit (115200 baud at 100 MHz); legal range 4..65535.
REQ-002 Parameter VALID_TIMEOUT, default 15: max clk100 cycles to wait for RD_VALID after RD_EN.
REQ-003 clk100  in  1  system clock, 100 MHz; the block's only clock, also drives the event FIFO read port.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 RD_EMPTY  in  1  event FIFO empty flag.
REQ-006 RD_VALID  in  1  event FIFO read data valid.
REQ-007 OTUBE  in  16  event FIFO read data word.
REQ-008 RD_EN  out  1  event FIFO read request, one-cycle pulse per word.
REQ-009 UART_TX  out  1  serial output, 8N1, idle high.
REQ-010 TX_BUSY  out  1  high from RD_EN pulse until the last stop bit of the frame ends.
REQ-011 FRAME_COUNT  out  16  frames fully transmitted since reset.
REQ-012 RD_ERR  out  1  sticky flag: a read timed out.

Function
REQ-013 FSM states: IDLE, REQ, WAIT_VALID, SEND, GAP.
REQ-014 IDLE -> REQ when RD_EMPTY=0; RD_EN SHALL never be high while RD_EMPTY=1 in the same cycle.
REQ-015 REQ: RD_EN=1 for exactly one cycle, then WAIT_VALID.
REQ-016 WAIT_VALID: on RD_VALID=1, latch OTUBE and go to SEND; if RD_VALID is not seen within VALID_TIMEOUT cycles, set RD_ERR and go to IDLE without sending.
REQ-017 Frame bytes in order: 0xA5 sync, OTUBE[15:8], OTUBE[7:0].
REQ-018 Each byte: start bit 0, 8 data bits LSB first, stop bit 1; every bit lasts exactly BAUD_DIV cycles.
REQ-019 Bytes within a frame are back-to-back, with no idle bits between a stop bit and the next start bit.
REQ-020 The UART_TX start bit of the sync byte SHALL begin on the cycle after RD_VALID is sampled.
REQ-021 GAP: UART_TX held high for one bit period after the frame; FRAME_COUNT increments by 1 at GAP entry; then IDLE.
REQ-022 FRAME_COUNT wraps from 0xFFFF to 0x0000.
REQ-023 OTUBE and RD_VALID are ignored outside WAIT_VALID.
REQ-024 A new word arriving in the FIFO while the block is busy is not read until the FSM returns to IDLE.
REQ-025 UART_TX is registered and glitch-free.

Reset
REQ-026 While rst_n=0: FSM=IDLE, RD_EN=0, UART_TX=1, TX_BUSY=0, FRAME_COUNT=0, RD_ERR=0, bit/baud counters=0.
REQ-027 Reset during a frame aborts it immediately: UART_TX=1 within the same cycle; the latched word is discarded and is not re-sent.
REQ-028 Release is synchronised internally; the first RD_EN is no earlier than the 2nd rising clk100 edge after rst_n rises.

Configuration
REQ-029 Macro EVT_CHECKSUM_EN defined: a 4th byte equal to the XOR of the three preceding bytes is appended to each frame, giving a 40-bit-period frame.
REQ-030 Macro EVT_CHECKSUM_EN undefined: the frame is 3 bytes (30 bit periods), and no checksum logic is synthesised.

Structure
REQ-031 Package qn17_pkg holds the FSM state enum, SYNC_BYTE=8'hA5, and FRAME_BYTES (3 or 4, selected by the macro).
REQ-032 Sub-module uart_tx_byte (inputs: start, data[7:0]; outputs: tx, done; parameter BAUD_DIV) serialises single bytes; event_uart_tx sequences the bytes.

Verification
REQ-033 BAUD_DIV=4, FIFO holds 0x1008, macro off -> exactly one RD_EN pulse; UART_TX decodes bytes A5,10,08; frame lasts 120 cycles; FRAME_COUNT=1.
REQ-034 Same stimulus, macro on -> bytes A5,10,08,BD; frame lasts 160 cycles.
REQ-035 Two words queued, 0x0201 then 0x0000 -> two frames in order; second RD_EN comes only after the GAP of the first frame; FRAME_COUNT=2; RD_EMPTY=1 afterwards gives no further RD_EN.
REQ-036 RD_VALID held low after RD_EN -> RD_ERR=1 after 15 cycles; UART_TX stays high; FRAME_COUNT unchanged.
REQ-037 rst_n pulsed low midway through the second byte -> UART_TX=1 at once and all outputs at reset values; after release with a word 0x1234 queued, a full frame A5,12,34 is sent.
REQ-038 FRAME_COUNT preloaded near 0xFFFF via forced state, 2 frames sent -> value 0x0000 then 0x0001.
